melody_seq: RTL

MELODY_SEQ -- requirements
Module: melody_seq

---
 rtl/melody_pkg.sv | 26 ++
 rtl/song_rom.sv | 11 +
 rtl/melody_seq.sv | 99 +++++++++
 3 files changed

// File: rtl/melody_pkg.sv
// melody_pkg: shared state encoding, song entry layout and default song table
package melody_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, FIN} state_t;
  localparam int ENTRY_W = 10;
  localparam int REST_BIT = 9;
  localparam int CODE_LSB = 5;
  localparam int CODE_W = 4;
  localparam int DUR_LSB = 0;
  localparam int DUR_W = 5;
  localparam int MAX_LEN = 256;
  localparam logic [DUR_W-1:0] END_MARK = '0;
  typedef logic [ENTRY_W-1:0] entry_t;
  typedef entry_t [MAX_LEN-1:0] song_t;
  function automatic entry_t note(input logic rest, input logic [CODE_W-1:0] code, input logic [DUR_W-1:0] dur);
    return {rest, code, dur};
  endfunction
  localparam song_t DEFAULT_SONG = song_t'({
    note(1'b0, 4'd0, END_MARK),
    note(1'b0, 4'd0, 5'd20),
    note(1'b0, 4'd4, 5'd10),
    note(1'b1, 4'd0, 5'd5),
    note(1'b0, 4'd2, 5'd10),
    note(1'b0, 4'd4, 5'd10),
    note(1'b0, 4'd0, 5'd10)
  });
endpackage

// File: rtl/song_rom.sv
// song_rom: combinational song table lookup
module song_rom
  import melody_pkg::*;
#(
  parameter song_t SONG = DEFAULT_SONG
) (
  input  logic [7:0] addr,
  output logic [9:0] entry
);
  assign entry = SONG[addr];
endmodule

// File: rtl/melody_seq.sv
// melody_seq: song sequencer FSM with tempo prescaler driving a one-hot tone output
module melody_seq
  import melody_pkg::*;
#(
  parameter int TICK_DIV = 1_000_000,
  parameter int SONG_LEN = 32,
  parameter song_t SONG = DEFAULT_SONG
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  output logic [15:0] tone,
  output logic        busy,
  output logic        done,
  output logic [7:0]  note_idx
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0] LAST_IDX = 8'(SONG_LEN - 1);
  state_t state, state_n;
  logic [PW-1:0] presc;
  logic [DUR_W-1:0] dur, dur_n, e_dur;
  logic [CODE_W-1:0] e_code;
  logic [15:0] tone_n;
  logic [7:0] idx_n;
  logic [9:0] entry;
  logic e_rest, tick, done_n;
  song_rom #(.SONG(SONG)) u_rom (.addr(note_idx), .entry(entry));
  assign e_dur = entry[DUR_LSB +: DUR_W];
  assign e_code = entry[CODE_LSB +: CODE_W];
  assign e_rest = entry[REST_BIT];
  assign tick = presc == TICK_LAST;
  always_comb begin
    state_n = state;
    idx_n = note_idx;
    dur_n = dur;
    tone_n = tone;
    done_n = 1'b0;
    if (stop) begin
      state_n = IDLE;
      idx_n = '0;
      tone_n = '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_n = LOAD;
          idx_n = '0;
        end
        LOAD: if (e_dur == END_MARK) state_n = FIN;
        else begin
          state_n = PLAY;
          dur_n = e_dur;
          tone_n = e_rest ? '0 : 16'(1) << e_code;
        end
        PLAY: if (tick) begin
          if (dur == 1) begin
            state_n = GAP;
            dur_n = '0;
            tone_n = '0;
          end else dur_n = dur - 1'b1;
        end
        GAP: if (tick) begin
          if (note_idx == LAST_IDX) state_n = FIN;
          else begin
            state_n = LOAD;
            idx_n = note_idx + 8'd1;
          end
        end
        FIN: begin
          state_n = loop_en ? LOAD : IDLE;
          idx_n = '0;
          done_n = !loop_en;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      presc <= '0;
      dur <= '0;
      note_idx <= '0;
      tone <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      presc <= (tick || !(state inside {PLAY, GAP})) ? '0 : presc + 1'b1;
      dur <= dur_n;
      note_idx <= idx_n;
      tone <= tone_n;
      busy <= state_n != IDLE;
      done <= done_n;
    end
  end
endmodule
